// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU. Single-cycle arithmetic, logic and load ops, plus iterative one-bit-per-cycle shifts.
// Define ALU_SEQ_MULDIV_EN to build the iterative MULU/DIVU datapath. Without it, every MULDIV code is undefined.
module alu_seq #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         inValid,
    output logic         inReady,
    input  logic [N-1:0] operand1,
    input  logic [N-1:0] operand2,
    input  logic         carryIn,
    input  logic [2:0]   operationType,
    input  logic [2:0]   operation,
    output logic         outValid,
    input  logic         outReady,
    output logic [N-1:0] result,
    output logic [N-1:0] resultHigh,
    output logic         carryOut,
    output logic         zeroOut,
    output logic         negativeOut,
    output logic         errorOut,
    output logic [1:0]   fsmState
);

    // Handshake: a request is accepted on an edge where inValid && inReady; a result is consumed on an
    // edge where outValid && outReady. inReady is high only in IDLE, and outValid is high only in DONE.

    localparam int H  = N / 2;
    localparam int CW = SW + 1;

    localparam logic [2:0] TYPE_ALU    = 3'b000;
    localparam logic [2:0] TYPE_SHIFT  = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_MULDIV = 3'b011;

    localparam logic [2:0] SH_SHR  = 3'b000;
    localparam logic [2:0] SH_SHL  = 3'b001;
    localparam logic [2:0] SH_ASHR = 3'b010;
    localparam logic [2:0] SH_ROR  = 3'b011;
    localparam logic [2:0] SH_ROL  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    iterOp;
    logic [N-1:0]  shReg;
    logic          shCarry;

    logic [N-1:0]  scResult;
    logic [N-1:0]  scHigh;
    logic          scCarry;
    logic          scError;
    logic          scIter;
    logic [CW-1:0] scCount;
    logic [N:0]    arith;
    logic [N-1:0]  shNext;
    logic          shCarryNext;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [2:0] MD_MULU = 3'b000;
    localparam logic [2:0] MD_DIVU = 3'b001;

    logic           iterMd;
    logic [N-1:0]   opB;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] accNext;
    logic [N:0]     mulSum;
    logic [N:0]     divRem;
    logic [N+1:0]   divDiff;
    logic           divBit;
`endif

    assign fsmState = state;

    // Single-cycle results and the decision whether the request needs iterating.
    always_comb begin
        scResult = operand1;
        scHigh   = '0;
        scCarry  = carryIn;
        scError  = 1'b0;
        scIter   = 1'b0;
        scCount  = '0;
        arith    = '0;
        case (operationType)
            TYPE_ALU: begin
                case (operation)
                    3'b000:  arith = {1'b0, operand1} + {1'b0, operand2};
                    3'b001:  arith = {1'b0, operand1} + {1'b0, operand2} + {{N{1'b0}}, carryIn};
                    3'b010:  arith = {1'b0, operand1} - {1'b0, operand2};
                    3'b011:  arith = {1'b0, operand1} - {1'b0, operand2} - {{N{1'b0}}, carryIn};
                    default: arith = '0;
                endcase
                case (operation)
                    3'b100:  scResult = operand1 & operand2;
                    3'b101:  scResult = operand1 | operand2;
                    3'b110:  scResult = operand1 ^ operand2;
                    3'b111:  scResult = ~operand1;
                    default: begin
                        scResult = arith[N-1:0];
                        scCarry  = arith[N];
                    end
                endcase
            end
            TYPE_SHIFT: begin
                if (operation > SH_ROL) begin
                    scError = 1'b1;
                end else if (operand2[SW-1:0] != '0) begin
                    scIter  = 1'b1;
                    scCount = {1'b0, operand2[SW-1:0]};
                end
            end
            TYPE_LOAD: begin
                case (operation)
                    3'b000:  scResult = operand1;
                    3'b001:  scResult = {{H{1'b0}}, operand1[H-1:0]};
                    3'b010:  scResult = {{H{1'b0}}, operand1[N-1:H]};
                    3'b011:  scResult = {operand1[H-1:0], operand1[N-1:H]};
                    3'b100:  scResult = {operand2[N-1:H], operand1[H-1:0]};
                    3'b101:  scResult = {operand1[N-1:H], operand2[H-1:0]};
                    3'b110:  scResult = {{H{1'b0}}, operand1[H-1:0]};
                    default: scResult = {operand1[N-1:H], {H{1'b0}}};
                endcase
            end
            TYPE_MULDIV: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (operation == MD_MULU) begin
                    scIter  = 1'b1;
                    scCount = CW'(N);
                end else if (operation == MD_DIVU) begin
                    if (operand2 == '0) begin
                        scResult = '1;
                        scHigh   = operand1;
                        scCarry  = 1'b0;
                        scError  = 1'b1;
                    end else begin
                        scIter  = 1'b1;
                        scCount = CW'(N);
                    end
                end else begin
                    scError = 1'b1;
                end
`else
                scError = 1'b1;
`endif
            end
            default: scError = 1'b1;
        endcase
    end

    // One shift step; the rotates treat {shCarry, shReg} as an (N+1)-bit ring.
    always_comb begin
        shNext      = shReg;
        shCarryNext = shCarry;
        case (iterOp)
            SH_SHR:  begin shNext = {1'b0, shReg[N-1:1]};      shCarryNext = shReg[0];   end
            SH_SHL:  begin shNext = {shReg[N-2:0], 1'b0};      shCarryNext = shReg[N-1]; end
            SH_ASHR: begin shNext = {shReg[N-1], shReg[N-1:1]}; shCarryNext = shReg[0];  end
            SH_ROR:  begin shNext = {shCarry, shReg[N-1:1]};   shCarryNext = shReg[0];   end
            SH_ROL:  begin shNext = {shReg[N-2:0], shCarry};   shCarryNext = shReg[N-1]; end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // acc starts as {0, operand1}: shift-add multiplier in the low half, or restoring-divide dividend.
    always_comb begin
        mulSum  = {1'b0, acc[2*N-1:N]} + {1'b0, opB & {N{acc[0]}}};
        divRem  = {acc[2*N-1:N], acc[N-1]};
        divDiff = {1'b0, divRem} - {2'b00, opB};
        divBit  = ~divDiff[N+1];
        if (iterOp == MD_MULU) begin
            accNext = {mulSum, acc[N-1:1]};
        end else begin
            accNext = {(divBit ? divDiff[N-1:0] : divRem[N-1:0]), acc[N-2:0], divBit};
        end
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            inReady     <= 1'b1;
            outValid    <= 1'b0;
            result      <= '0;
            resultHigh  <= '0;
            carryOut    <= 1'b0;
            zeroOut     <= 1'b0;
            negativeOut <= 1'b0;
            errorOut    <= 1'b0;
            cnt         <= '0;
            iterOp      <= '0;
            shReg       <= '0;
            shCarry     <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            iterMd      <= 1'b0;
            opB         <= '0;
            acc         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        inReady <= 1'b0;
                        if (scIter) begin
                            state   <= EXEC;
                            cnt     <= scCount;
                            iterOp  <= operation;
                            shReg   <= operand1;
                            shCarry <= carryIn;
`ifdef ALU_SEQ_MULDIV_EN
                            iterMd  <= (operationType == TYPE_MULDIV);
                            opB     <= operand2;
                            acc     <= {{N{1'b0}}, operand1};
`endif
                        end else begin
                            state       <= DONE;
                            outValid    <= 1'b1;
                            result      <= scResult;
                            resultHigh  <= scHigh;
                            carryOut    <= scCarry;
                            zeroOut     <= (scResult == '0);
                            negativeOut <= scResult[N-1];
                            errorOut    <= scError;
                        end
                    end
                end
                EXEC: begin
                    cnt     <= cnt - CW'(1);
                    shReg   <= shNext;
                    shCarry <= shCarryNext;
`ifdef ALU_SEQ_MULDIV_EN
                    acc     <= accNext;
`endif
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        outValid <= 1'b1;
                        errorOut <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
                        if (iterMd) begin
                            result      <= accNext[N-1:0];
                            resultHigh  <= accNext[2*N-1:N];
                            carryOut    <= 1'b0;
                            negativeOut <= accNext[N-1];
                            zeroOut     <= (iterOp == MD_MULU) ? (accNext == '0) : (accNext[N-1:0] == '0);
                        end else
`endif
                        begin
                            result      <= shNext;
                            resultHigh  <= '0;
                            carryOut    <= shCarryNext;
                            negativeOut <= shNext[N-1];
                            zeroOut     <= (shNext == '0);
                        end
                    end
                end
                DONE: begin
                    if (outReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against a behavioural reference model, with a scoreboard queue.
module tb_alu_seq;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] hi;
        logic        c;
        logic        z;
        logic        n;
        logic        e;
        logic [7:0]  lat;
    } exp_t;

    localparam int EW = $bits(exp_t);

    logic        clk;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        carryIn;
    logic [2:0]  operationType;
    logic [2:0]  operation;
    logic        outValid;
    logic        outReady;
    logic [15:0] result;
    logic [15:0] resultHigh;
    logic        carryOut;
    logic        zeroOut;
    logic        negativeOut;
    logic        errorOut;
    logic [1:0]  fsmState;

    logic [EW-1:0] exp_q[$];
    int compared;
    int mismatched;

    alu_seq dut (
        .clk           (clk),
        .resetN        (resetN),
        .inValid       (inValid),
        .inReady       (inReady),
        .operand1      (operand1),
        .operand2      (operand2),
        .carryIn       (carryIn),
        .operationType (operationType),
        .operation     (operation),
        .outValid      (outValid),
        .outReady      (outReady),
        .result        (result),
        .resultHigh    (resultHigh),
        .carryOut      (carryOut),
        .zeroOut       (zeroOut),
        .negativeOut   (negativeOut),
        .errorOut      (errorOut),
        .fsmState      (fsmState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   input logic [2:0] typ, input logic [2:0] op);
        exp_t        e;
        int          ia;
        int          ib;
        int          ic;
        int          k;
        logic [16:0] ring;
        logic [31:0] p;
        ia = a;
        ib = b;
        ic = cin;
        e = '0;
        e.res = a;
        e.c = cin;
        e.lat = 8'd1;
        case (typ)
            3'd0: begin
                case (op)
                    3'd0: begin p = 32'(ia + ib);      e.res = p[15:0]; e.c = (ia + ib > 65535); end
                    3'd1: begin p = 32'(ia + ib + ic); e.res = p[15:0]; e.c = (ia + ib + ic > 65535); end
                    3'd2: begin p = 32'(ia - ib);      e.res = p[15:0]; e.c = (ia < ib); end
                    3'd3: begin p = 32'(ia - ib - ic); e.res = p[15:0]; e.c = (ia < ib + ic); end
                    3'd4: e.res = a & b;
                    3'd5: e.res = a | b;
                    3'd6: e.res = a ^ b;
                    default: e.res = ~a;
                endcase
            end
            3'd1: begin
                k = int'(b[3:0]);
                if (op > 3'd4) begin
                    e.e = 1'b1;
                end else if (k != 0) begin
                    e.lat = 8'(k + 1);
                    case (op)
                        3'd0: begin e.res = a >> k; e.c = a[k-1]; end
                        3'd1: begin e.res = a << k; e.c = a[16-k]; end
                        3'd2: begin e.res = 16'($signed(a) >>> k); e.c = a[k-1]; end
                        default: begin
                            ring = {cin, a};
                            for (int i = 0; i < k; i++) begin
                                if (op == 3'd3) ring = {ring[0], ring[16:1]};
                                else ring = {ring[15:0], ring[16]};
                            end
                            e.res = ring[15:0];
                            e.c = ring[16];
                        end
                    endcase
                end
            end
            3'd2: begin
                case (op)
                    3'd0: e.res = a;
                    3'd1: e.res = {8'h00, a[7:0]};
                    3'd2: e.res = {8'h00, a[15:8]};
                    3'd3: e.res = {a[7:0], a[15:8]};
                    3'd4: e.res = {b[15:8], a[7:0]};
                    3'd5: e.res = {a[15:8], b[7:0]};
                    3'd6: e.res = {8'h00, a[7:0]};
                    default: e.res = {a[15:8], 8'h00};
                endcase
            end
            3'd3: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (op == 3'd0) begin
                    p = {16'h0000, a} * {16'h0000, b};
                    e.res = p[15:0];
                    e.hi = p[31:16];
                    e.c = 1'b0;
                    e.lat = 8'd17;
                end else if (op == 3'd1) begin
                    e.c = 1'b0;
                    if (b == 16'h0000) begin
                        e.res = 16'hFFFF;
                        e.hi = a;
                        e.e = 1'b1;
                    end else begin
                        e.res = a / b;
                        e.hi = a % b;
                        e.lat = 8'd17;
                    end
                end else begin
                    e.e = 1'b1;
                end
`else
                e.e = 1'b1;
`endif
            end
            default: e.e = 1'b1;
        endcase
        e.n = e.res[15];
        e.z = (e.res == 16'h0000);
`ifdef ALU_SEQ_MULDIV_EN
        if (typ == 3'd3 && op == 3'd0) e.z = (p == 32'h0);
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_fields(input exp_t e);
        check("result", result, e.res);
        check("result_high", resultHigh, e.hi);
        check("carry_out", carryOut, e.c);
        check("zero_out", zeroOut, e.z);
        check("negative_out", negativeOut, e.n);
        check("error_out", errorOut, e.e);
        check("out_valid_held", outValid, 1);
        check("in_ready_busy", inReady, 0);
        check("state_done", fsmState, 2);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", inReady, 1);
        check("rst_out_valid", outValid, 0);
        check("rst_result", result, 0);
        check("rst_result_high", resultHigh, 0);
        check("rst_flags", {carryOut, zeroOut, negativeOut, errorOut}, 0);
        check("rst_state", fsmState, 0);
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        #3;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [2:0] typ, input logic [2:0] op, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("in_ready_idle", inReady, 1);
        operand1 = a;
        operand2 = b;
        carryIn = cin;
        operationType = typ;
        operation = op;
        inValid = 1'b1;
        exp_q.push_back(model(a, b, cin, typ, op));
        @(posedge clk);
        #1;
        inValid = 1'b0;
        operand1 = 16'($urandom);
        operand2 = 16'($urandom);
        carryIn = 1'($urandom_range(0, 1));
        operationType = 3'($urandom_range(0, 7));
        operation = 3'($urandom_range(0, 7));
        lat = 1;
        while (!outValid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        if (!outValid) begin
            check("timeout", 0, 1);
            pulse_reset();
            return;
        end
        check("latency", lat, 32'(e.lat));
        check_fields(e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_fields(e);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check("out_valid_fall", outValid, 0);
        check("in_ready_back", inReady, 1);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        resetN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        operand1 = '0;
        operand2 = '0;
        carryIn = 1'b0;
        operationType = '0;
        operation = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        resetN = 1'b1;

        // ALU
        do_op(16'hFFFF, 16'h0001, 1'b0, 3'd0, 3'd0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 3'd0, 3'd1, 0);
        do_op(16'h0005, 16'h0007, 1'b0, 3'd0, 3'd2, 0);
        do_op(16'h0000, 16'h0000, 1'b1, 3'd0, 3'd3, 0);
        do_op(16'hF0F0, 16'h3C3C, 1'b1, 3'd0, 3'd4, 0);
        do_op(16'hF0F0, 16'h3C3C, 1'b0, 3'd0, 3'd5, 0);
        do_op(16'hF0F0, 16'h3C3C, 1'b1, 3'd0, 3'd6, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 3'd0, 3'd7, 0);

        // LOAD
        for (int i = 0; i < 8; i++) do_op(16'hA5C3, 16'h3C96, 1'b1, 3'd2, 3'(i), 0);

        // SHIFT
        do_op(16'h8001, 16'h0003, 1'b0, 3'd1, 3'd1, 0);
        do_op(16'h0001, 16'h0001, 1'b1, 3'd1, 3'd3, 0);
        do_op(16'hF00F, 16'h0004, 1'b0, 3'd1, 3'd0, 0);
        do_op(16'h8010, 16'h0004, 1'b0, 3'd1, 3'd2, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 3'd1, 3'd4, 0);
        do_op(16'h1234, 16'h0000, 1'b1, 3'd1, 3'd1, 0);
        do_op(16'hFFFF, 16'h000F, 1'b0, 3'd1, 3'd1, 0);
        do_op(16'h1234, 16'h0003, 1'b1, 3'd1, 3'd5, 0);

        // MULDIV and undefined type
        do_op(16'h1234, 16'h0100, 1'b0, 3'd3, 3'd0, 0);
        do_op(16'd100, 16'd7, 1'b0, 3'd3, 3'd1, 0);
        do_op(16'd5, 16'd0, 1'b1, 3'd3, 3'd1, 0);
        do_op(16'd3, 16'd4, 1'b1, 3'd3, 3'd0, 0);
        do_op(16'h0000, 16'h0005, 1'b0, 3'd3, 3'd0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 3'd3, 3'd0, 0);
        do_op(16'h1234, 16'h0001, 1'b1, 3'd3, 3'd2, 0);
        do_op(16'h4321, 16'h0001, 1'b0, 3'd5, 3'd0, 0);

        // Backpressure
        do_op(16'h00F0, 16'h0002, 1'b0, 3'd1, 3'd0, 5);
        do_op(16'h7FFF, 16'h0001, 1'b0, 3'd0, 3'd0, 5);

        // Random
        for (int i = 0; i < 30; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), $urandom_range(0, 2));
        end

        // Reset in the middle of an iterative operation: nothing may come out for it.
        @(negedge clk);
        operand1 = 16'h1234;
`ifdef ALU_SEQ_MULDIV_EN
        operand2 = 16'h0100;
        operationType = 3'd3;
        operation = 3'd0;
`else
        operand2 = 16'h000F;
        operationType = 3'd1;
        operation = 3'd1;
`endif
        carryIn = 1'b1;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("abort_busy_valid", outValid, 0);
        check("abort_busy_ready", inReady, 0);
        resetN = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        resetN = 1'b1;
        do_op(16'h0101, 16'h0202, 1'b0, 3'd0, 3'd0, 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, parametrised successor to the datapath ALU. It adds iterative multi-bit shifts, and optionally unsigned multiply and divide, on top of the existing single-cycle arithmetic, logic and load operations. Operands enter and results leave through valid/ready handshakes. The block sits between register-file read and write-back and stalls the CPU sequencer through `inReady` while an iterative operation runs.

## Interface
Parameters:
- `N`, 16: datapath width; must be even and ≥ 8.
- `SW`, 4: shift-count width, equal to clog2(N).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `inValid` in 1: request present.
- `inReady` out 1: request accepted on any edge where both `inValid` and `inReady` are 1.
- `operand1` in N: first operand.
- `operand2` in N: second operand. For shifts, `operand2[SW-1:0]` is the shift count.
- `carryIn` in 1: carry flag input.
- `operationType` in 3: 000 ALU, 001 SHIFT, 010 LOAD, 011 MULDIV.
- `operation` in 3: operation code within the selected type.
- `outValid` out 1: result present.
- `outReady` in 1: result consumed on any edge where both `outValid` and `outReady` are 1.
- `result` out N: primary result.
- `resultHigh` out N: multiply high word or divide remainder; 0 for all other operations.
- `carryOut`, `zeroOut`, `negativeOut`, `errorOut` out 1 each: registered flags.

## Operation
- Operands, type, operation and `carryIn` are captured at acceptance. Later input changes have no effect.
- States:
  - IDLE: `inReady` = 1.
  - EXEC: iterating; an internal counter holds the remaining iterations.
  - DONE: `outValid` = 1.
- Transitions:
  - IDLE to DONE: single-cycle operations.
  - IDLE to EXEC: iterative operations.
  - EXEC to DONE: when the counter reaches 0.
  - DONE to IDLE: on `outReady`.
- ALU ops: ADD 000, ADC 001, SUB 010, SBC 011, AND 100, OR 101, XOR 110, NOT 111.
  - All arithmetic is N+1 bits wide.
  - For SUB and SBC, `carryOut` is the borrow, i.e. bit N of the zero-extended difference.
  - Logic ops pass `carryIn` through to `carryOut`.
- SHIFT ops: SHR 000, SHL 001, ASHR 010, ROR 011, ROL 100. Each iteration shifts one bit.
  - `carryOut` is the last bit shifted out.
  - ROR and ROL rotate through the carry as an (N+1)-bit ring.
  - A shift count of 0 gives `result` = `operand1` and `carryOut` = `carryIn`.
- LOAD ops (H = N/2):
  - COPY 000: `operand1`.
  - LDL 001: zero-extended low half of `operand1`.
  - LDH 010: zero-extended high half of `operand1`.
  - SWAP 011: the two halves of `operand1` exchanged.
  - LDLI 100: {`operand2` high half, `operand1` low half}.
  - LDHI 101: {`operand1` high half, `operand2` low half}.
  - LDLZI 110: {0, `operand1` low half}.
  - LDHZI 111: {`operand1` high half, 0}.
  - `carryOut` = `carryIn` for all LOAD ops.
- MULDIV ops:
  - MULU 000: shift-add, N iterations. {`resultHigh`, `result`} = the 2N-bit product.
  - DIVU 001: restoring division, N iterations. `result` = quotient, `resultHigh` = remainder.
  - `carryOut` = 0 for both.
  - Divide by zero completes in a single cycle: `result` = all ones, `resultHigh` = `operand1`, `errorOut` = 1.
- Flags:
  - `negativeOut` = `result[N-1]`.
  - `zeroOut` = (`result` == 0). For MULU it is computed over the full 2N-bit product.
- Undefined codes (SHIFT 101–111, MULDIV 010–111, type 100–111) complete in a single cycle with `result` = `operand1`, `carryOut` = `carryIn`, `errorOut` = 1.

## Timing
- Reset: state is IDLE, `inReady` = 1, `outValid` = 0, and every other output is 0.
- Latency is counted from the accept edge to the edge at which `outValid` rises:
  - single-cycle ops: 1;
  - shift by k (k > 0): k + 1;
  - MULU and DIVU: N + 1.
- `inReady` is 0 in EXEC and DONE, so at most one request is in flight. The minimum spacing between accepts is 2 cycles.
- While `outValid` = 1 and `outReady` = 0, all outputs hold stable.
- The result is consumed on the edge where `outValid` and `outReady` are both 1. The state returns to IDLE on that edge and `outValid` falls on it.
- Reset asserted mid-EXEC or in DONE aborts the operation immediately. No result is ever produced for it.
- Outputs are registered. No combinational path runs from inputs to `result` or to the flags.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: MULU and DIVU are present as specified, including the multiply/divide datapath and the 2N-bit accumulator.
- Not defined:
  - The multiply/divide logic is removed.
  - Every MULDIV code is treated as undefined: 1-cycle latency, `errorOut` = 1, `result` = `operand1`, `resultHigh` = 0.

## Test plan
- ADD 0xFFFF + 0x0001, `carryIn` = 0 -> `result` 0x0000, `carryOut` 1, `zeroOut` 1; `outValid` rises 1 cycle after accept.
- SHL 0x8001 by 3 -> `result` 0x0008, `carryOut` 0, `outValid` after 4 cycles. ROR 0x0001 by 1 with `carryIn` = 1 -> `result` 0x8000, `carryOut` 1.
- MULU 0x1234 × 0x0100 -> `result` 0x3400, `resultHigh` 0x0012, latency 17. DIVU 100 / 7 -> `result` 14, `resultHigh` 2. DIVU 5 / 0 -> `result` 0xFFFF, `resultHigh` 5, `errorOut` 1, latency 1.
- Backpressure: hold `outReady` low for 5 cycles after `outValid` rises -> outputs stable and `inReady` 0 throughout; accept resumes on the cycle after `outReady` is sampled high.
- Reset mid-MULU, asserted at cycle 8 -> all outputs 0 and `inReady` 1; a following ADD completes normally.
- Build without `ALU_SEQ_MULDIV_EN`: MULU 3 × 4 -> `errorOut` 1, `result` 3, latency 1.
